// File: rtl/neighbor_table_builder.sv
// Walks the OBJ face list and builds a strided per-vertex adjacency table in NBR RAM.
// Build option: define NBR_CLEAR_EN to zero the table words 0..V*STRIDE-1 before the face walk.
module neighbor_table_builder #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int MAX_NBR = 10,
  parameter int CNT_W   = $clog2(MAX_NBR + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   RAM_OBJ_Do,
  input  logic [DATA_W-1:0]   RAM_NBR_Do,
  output logic                RAM_OBJ_EN,
  output logic                RAM_NBR_EN,
  output logic [ADDR_W-1:0]   RAM_OBJ_A,
  output logic [ADDR_W-1:0]   RAM_NBR_A,
  output logic [DATA_W/8-1:0] RAM_OBJ_WE,
  output logic [DATA_W/8-1:0] RAM_NBR_WE,
  output logic [DATA_W-1:0]   RAM_OBJ_Di,
  output logic [DATA_W-1:0]   RAM_NBR_Di,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                err,
  output logic [3:0]          state_dbg
);

  localparam int STRIDE = MAX_NBR + 1;
  localparam int BE_W   = DATA_W / 8;
  localparam int PW     = DATA_W + 32;
  localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(STRIDE);
  localparam logic [PW-1:0]     TBL_LIMIT = PW'(1) << ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_NBR);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_V, S_RD_F, S_CLEAR, S_RD_FACE,
    S_PAIR, S_LOOKUP, S_SCAN, S_APPEND, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          ph_q, ph_d;
  logic                obj_en_q, obj_en_d, nbr_en_q, nbr_en_d;
  logic [ADDR_W-1:0]   obj_a_q, obj_a_d, nbr_a_q, nbr_a_d;
  logic [BE_W-1:0]     nbr_we_q, nbr_we_d;
  logic [DATA_W-1:0]   nbr_di_q, nbr_di_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                ovf_q, ovf_d, err_q, err_d;
  logic [DATA_W-1:0]   v_q, v_d, f_q, f_d, face_n_q, face_n_d;
  logic [DATA_W-1:0]   ia_q, ia_d, ib_q, ib_d, ic_q, ic_d;
  logic [ADDR_W-1:0]   fptr_q, fptr_d, base_q, base_d;
  logic [2:0]          pair_q, pair_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, slot_q, slot_d;
`ifdef NBR_CLEAR_EN
  logic [ADDR_W:0]     clr_n_q, clr_n_d, tbl_n_q, tbl_n_d;
`endif

  logic [DATA_W-1:0]   curr, test;
  logic [ADDR_W-1:0]   base_calc;
  logic [PW-1:0]       tbl_words;
  logic                adv_pair, go_done, decide;
  logic [CNT_W-1:0]    dec_cnt;

  function automatic logic idx_bad(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] v);
    return (x == '0) || (x > v);
  endfunction

  // Ordered pairs (a,b),(a,c),(b,a),(b,c),(c,a),(c,b)
  always_comb begin
    curr = ia_q;
    test = ib_q;
    case (pair_q)
      3'd1:    begin curr = ia_q; test = ic_q; end
      3'd2:    begin curr = ib_q; test = ia_q; end
      3'd3:    begin curr = ib_q; test = ic_q; end
      3'd4:    begin curr = ic_q; test = ia_q; end
      3'd5:    begin curr = ic_q; test = ib_q; end
      default: begin curr = ia_q; test = ib_q; end
    endcase
  end

  assign base_calc = (curr[ADDR_W-1:0] - ADDR_W'(1)) * STRIDE_A;
  assign tbl_words = PW'(v_q) * PW'(STRIDE);

  always_comb begin
    state_d  = state_q;   ph_d     = ph_q;
    obj_en_d = obj_en_q;  nbr_en_d = nbr_en_q;
    obj_a_d  = obj_a_q;   nbr_a_d  = nbr_a_q;
    nbr_we_d = nbr_we_q;  nbr_di_d = nbr_di_q;
    busy_d   = busy_q;    done_d   = 1'b0;
    ovf_d    = ovf_q;     err_d    = err_q;
    v_d      = v_q;       f_d      = f_q;      face_n_d = face_n_q;
    ia_d     = ia_q;      ib_d     = ib_q;     ic_d     = ic_q;
    fptr_d   = fptr_q;    base_d   = base_q;   pair_d   = pair_q;
    cnt_d    = cnt_q;     slot_d   = slot_q;
`ifdef NBR_CLEAR_EN
    clr_n_d  = clr_n_q;   tbl_n_d  = tbl_n_q;
`endif
    adv_pair = 1'b0;
    go_done  = 1'b0;
    decide   = 1'b0;
    dec_cnt  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RD_V;
          ph_d     = 3'd0;
          busy_d   = 1'b1;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          obj_en_d = 1'b1;
          obj_a_d  = '0;
        end
      end
      S_RD_V: begin
        if (ph_q == 3'd0) ph_d = 3'd1;
        else begin
          v_d     = RAM_OBJ_Do;
          obj_a_d = RAM_OBJ_Do[ADDR_W-1:0] * ADDR_W'(3) + ADDR_W'(1);
          state_d = S_RD_F;
          ph_d    = 3'd0;
        end
      end
      S_RD_F: begin
        if (ph_q == 3'd0) ph_d = 3'd1;
        else begin
          f_d      = RAM_OBJ_Do;
          fptr_d   = obj_a_q + ADDR_W'(1);
          face_n_d = '0;
          obj_en_d = 1'b0;
          ph_d     = 3'd0;
          if (tbl_words > TBL_LIMIT) begin
            err_d   = 1'b1;
            go_done = 1'b1;
          end else begin
`ifdef NBR_CLEAR_EN
            tbl_n_d = tbl_words[ADDR_W:0];
            if (tbl_words == '0) state_d = S_RD_FACE;
            else begin
              state_d  = S_CLEAR;
              nbr_en_d = 1'b1;
              nbr_we_d = '1;
              nbr_di_d = '0;
              nbr_a_d  = '0;
              clr_n_d  = (ADDR_W+1)'(1);
            end
`else
            state_d = S_RD_FACE;
`endif
          end
        end
      end
`ifdef NBR_CLEAR_EN
      S_CLEAR: begin
        if (clr_n_q == tbl_n_q) begin
          nbr_en_d = 1'b0;
          nbr_we_d = '0;
          state_d  = S_RD_FACE;
          ph_d     = 3'd0;
        end else begin
          nbr_a_d = clr_n_q[ADDR_W-1:0];
          clr_n_d = clr_n_q + (ADDR_W+1)'(1);
        end
      end
`endif
      // Three back-to-back reads; data for address k lands two phases later
      S_RD_FACE: begin
        case (ph_q)
          3'd0: begin
            if (face_n_q == f_q) go_done = 1'b1;
            else begin
              obj_en_d = 1'b1;
              obj_a_d  = fptr_q;
              fptr_d   = fptr_q + ADDR_W'(1);
              ph_d     = 3'd1;
            end
          end
          3'd1: begin
            obj_a_d = fptr_q;
            fptr_d  = fptr_q + ADDR_W'(1);
            ph_d    = 3'd2;
          end
          3'd2: begin
            obj_a_d = fptr_q;
            fptr_d  = fptr_q + ADDR_W'(1);
            ia_d    = RAM_OBJ_Do;
            ph_d    = 3'd3;
          end
          3'd3: begin
            ib_d     = RAM_OBJ_Do;
            obj_en_d = 1'b0;
            ph_d     = 3'd4;
          end
          default: begin
            ic_d     = RAM_OBJ_Do;
            face_n_d = face_n_q + DATA_W'(1);
            ph_d     = 3'd0;
            if (idx_bad(ia_q, v_q) || idx_bad(ib_q, v_q) || idx_bad(RAM_OBJ_Do, v_q))
              err_d = 1'b1;
            else begin
              state_d = S_PAIR;
              pair_d  = 3'd0;
            end
          end
        endcase
      end
      S_PAIR: begin
        if (curr == test) adv_pair = 1'b1;
        else begin
          base_d   = base_calc;
          nbr_en_d = 1'b1;
          nbr_a_d  = base_calc;
          state_d  = S_LOOKUP;
          ph_d     = 3'd0;
        end
      end
      // Slot 1 is requested speculatively while the count is still in flight
      S_LOOKUP: begin
        if (ph_q == 3'd0) begin
          nbr_a_d = base_q + ADDR_W'(1);
          ph_d    = 3'd1;
        end else begin
          cnt_d   = RAM_NBR_Do[CNT_W-1:0];
          nbr_a_d = nbr_a_q + ADDR_W'(1);
          if (RAM_NBR_Do[CNT_W-1:0] == '0) begin
            decide  = 1'b1;
            dec_cnt = '0;
          end else begin
            state_d = S_SCAN;
            slot_d  = CNT_W'(1);
          end
        end
      end
      S_SCAN: begin
        nbr_a_d = nbr_a_q + ADDR_W'(1);
        if (RAM_NBR_Do == test) adv_pair = 1'b1;
        else if (slot_q == cnt_q) begin
          decide  = 1'b1;
          dec_cnt = cnt_q;
        end else slot_d = slot_q + CNT_W'(1);
      end
      S_APPEND: begin
        if (ph_q == 3'd0) begin
          nbr_a_d  = base_q;
          nbr_di_d = DATA_W'(cnt_q) + DATA_W'(1);
          ph_d     = 3'd1;
        end else adv_pair = 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (decide) begin
      if (dec_cnt >= CNT_MAX) begin
        ovf_d    = 1'b1;
        adv_pair = 1'b1;
      end else begin
        state_d  = S_APPEND;
        ph_d     = 3'd0;
        cnt_d    = dec_cnt;
        nbr_a_d  = base_q + ADDR_W'(dec_cnt) + ADDR_W'(1);
        nbr_we_d = '1;
        nbr_di_d = test;
      end
    end

    if (adv_pair) begin
      nbr_en_d = 1'b0;
      nbr_we_d = '0;
      if (pair_q == 3'd5) begin
        state_d = S_RD_FACE;
        ph_d    = 3'd0;
      end else begin
        pair_d  = pair_q + 3'd1;
        state_d = S_PAIR;
      end
    end

    if (go_done) begin
      state_d  = S_DONE;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      obj_en_d = 1'b0;
      nbr_en_d = 1'b0;
      nbr_we_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;   ph_q     <= '0;
      obj_en_q <= 1'b0;     nbr_en_q <= 1'b0;
      obj_a_q  <= '0;       nbr_a_q  <= '0;
      nbr_we_q <= '0;       nbr_di_q <= '0;
      busy_q   <= 1'b0;     done_q   <= 1'b0;
      ovf_q    <= 1'b0;     err_q    <= 1'b0;
      v_q      <= '0;       f_q      <= '0;     face_n_q <= '0;
      ia_q     <= '0;       ib_q     <= '0;     ic_q     <= '0;
      fptr_q   <= '0;       base_q   <= '0;     pair_q   <= '0;
      cnt_q    <= '0;       slot_q   <= '0;
`ifdef NBR_CLEAR_EN
      clr_n_q  <= '0;       tbl_n_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;  ph_q     <= ph_d;
      obj_en_q <= obj_en_d; nbr_en_q <= nbr_en_d;
      obj_a_q  <= obj_a_d;  nbr_a_q  <= nbr_a_d;
      nbr_we_q <= nbr_we_d; nbr_di_q <= nbr_di_d;
      busy_q   <= busy_d;   done_q   <= done_d;
      ovf_q    <= ovf_d;    err_q    <= err_d;
      v_q      <= v_d;      f_q      <= f_d;    face_n_q <= face_n_d;
      ia_q     <= ia_d;     ib_q     <= ib_d;   ic_q     <= ic_d;
      fptr_q   <= fptr_d;   base_q   <= base_d; pair_q   <= pair_d;
      cnt_q    <= cnt_d;    slot_q   <= slot_d;
`ifdef NBR_CLEAR_EN
      clr_n_q  <= clr_n_d;  tbl_n_q  <= tbl_n_d;
`endif
    end
  end

  assign RAM_OBJ_EN = obj_en_q;
  assign RAM_OBJ_A  = obj_a_q;
  assign RAM_OBJ_WE = '0;
  assign RAM_OBJ_Di = '0;
  assign RAM_NBR_EN = nbr_en_q;
  assign RAM_NBR_A  = nbr_a_q;
  assign RAM_NBR_WE = nbr_we_q;
  assign RAM_NBR_Di = nbr_di_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign err        = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_neighbor_table_builder.sv
// Directed bench for neighbor_table_builder: instance a uses MAX_NBR=10, instance b MAX_NBR=2;
// both read one OBJ image and own separate NBR RAM models.
module tb_neighbor_table_builder;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] obj_mem   [0:511];
  logic [DW-1:0] nbr_a_mem [0:511];
  logic [DW-1:0] nbr_b_mem [0:511];
  logic          tb_wipe;
  logic [DW-1:0] tb_wipe_val;
  logic          start_req, run_sel;

  logic [DW-1:0] a_obj_do, a_nbr_do, a_obj_di, a_nbr_di, b_obj_do, b_nbr_do, b_obj_di, b_nbr_di;
  logic          a_obj_en, a_nbr_en, b_obj_en, b_nbr_en;
  logic [AW-1:0] a_obj_addr, a_nbr_addr, b_obj_addr, b_nbr_addr;
  logic [BW-1:0] a_obj_we, a_nbr_we, b_obj_we, b_nbr_we;
  logic          a_busy, a_done, a_ovf, a_err, b_busy, b_done, b_ovf, b_err;
  logic [3:0]    a_state, b_state;
  logic          a_start, b_start;
  logic          r_busy, r_done, r_ovf, r_err;
  logic [AW-1:0] r_obj_addr;

  assign a_start    = start_req & ~run_sel;
  assign b_start    = start_req & run_sel;
  assign r_busy     = run_sel ? b_busy : a_busy;
  assign r_done     = run_sel ? b_done : a_done;
  assign r_ovf      = run_sel ? b_ovf  : a_ovf;
  assign r_err      = run_sel ? b_err  : a_err;
  assign r_obj_addr = run_sel ? b_obj_addr : a_obj_addr;

  neighbor_table_builder #(.ADDR_W(AW), .DATA_W(DW), .MAX_NBR(10)) dut_a (
    .clk(clk), .rst(rst), .start(a_start),
    .RAM_OBJ_Do(a_obj_do), .RAM_NBR_Do(a_nbr_do),
    .RAM_OBJ_EN(a_obj_en), .RAM_NBR_EN(a_nbr_en),
    .RAM_OBJ_A(a_obj_addr), .RAM_NBR_A(a_nbr_addr),
    .RAM_OBJ_WE(a_obj_we), .RAM_NBR_WE(a_nbr_we),
    .RAM_OBJ_Di(a_obj_di), .RAM_NBR_Di(a_nbr_di),
    .busy(a_busy), .done(a_done), .overflow(a_ovf), .err(a_err), .state_dbg(a_state)
  );

  neighbor_table_builder #(.ADDR_W(AW), .DATA_W(DW), .MAX_NBR(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start),
    .RAM_OBJ_Do(b_obj_do), .RAM_NBR_Do(b_nbr_do),
    .RAM_OBJ_EN(b_obj_en), .RAM_NBR_EN(b_nbr_en),
    .RAM_OBJ_A(b_obj_addr), .RAM_NBR_A(b_nbr_addr),
    .RAM_OBJ_WE(b_obj_we), .RAM_NBR_WE(b_nbr_we),
    .RAM_OBJ_Di(b_obj_di), .RAM_NBR_Di(b_nbr_di),
    .busy(b_busy), .done(b_done), .overflow(b_ovf), .err(b_err), .state_dbg(b_state)
  );

  // synchronous RAM models, 1-cycle read latency, byte write enables
  always @(posedge clk) begin
    if (a_obj_en) a_obj_do <= obj_mem[a_obj_addr];
    if (b_obj_en) b_obj_do <= obj_mem[b_obj_addr];
    if (tb_wipe) begin
      for (int i = 0; i < 512; i++) begin
        nbr_a_mem[i] <= tb_wipe_val;
        nbr_b_mem[i] <= tb_wipe_val;
      end
    end else begin
      if (a_nbr_en) begin
        a_nbr_do <= nbr_a_mem[a_nbr_addr];
        for (int k = 0; k < BW; k++)
          if (a_nbr_we[k]) nbr_a_mem[a_nbr_addr][8*k +: 8] <= a_nbr_di[8*k +: 8];
      end
      if (b_nbr_en) begin
        b_nbr_do <= nbr_b_mem[b_nbr_addr];
        for (int k = 0; k < BW; k++)
          if (b_nbr_we[k]) nbr_b_mem[b_nbr_addr][8*k +: 8] <= b_nbr_di[8*k +: 8];
      end
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  int faces[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] nbr_rd(input int addr);
    return run_sel ? nbr_b_mem[addr] : nbr_a_mem[addr];
  endfunction

  task automatic check_tbl(input string tag, input int base);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), nbr_rd(base + i), exp_q[i]);
  endtask

  // driver tasks
  task automatic wipe(input logic [DW-1:0] val);
    @(negedge clk);
    tb_wipe = 1'b1;
    tb_wipe_val = val;
    @(negedge clk);
    tb_wipe = 1'b0;
  endtask

  task automatic load_obj(input int v);
    int p;
    obj_mem[0] = v;
    for (int i = 1; i <= 3 * v; i++) obj_mem[i % 512] = $urandom;
    obj_mem[(3 * v + 1) % 512] = faces.size() / 3;
    p = 3 * v + 2;
    foreach (faces[i]) obj_mem[(p + i) % 512] = faces[i];
  endtask

  task automatic run(input string tag, input logic sel);
    int cyc, n_done, stop_at;
    cyc = 0;
    n_done = 0;
    stop_at = -1;
    run_sel = sel;
    @(negedge clk);
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    check({tag, ".busy_after_start"}, r_busy, 1);
    check({tag, ".obj_addr_after_start"}, r_obj_addr, 0);
    while (cyc < 4000 && (stop_at < 0 || cyc < stop_at)) begin
      @(negedge clk);
      cyc++;
      if (r_done) begin
        n_done++;
        if (stop_at < 0) begin
          stop_at = cyc + 3;
          check({tag, ".busy_at_done"}, r_busy, 0);
        end
      end
    end
    check({tag, ".done_pulses"}, n_done, 1);
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, ".obj_en"}, a_obj_en, 0);
    check({tag, ".nbr_en"}, a_nbr_en, 0);
    check({tag, ".obj_a"}, a_obj_addr, 0);
    check({tag, ".nbr_a"}, a_nbr_addr, 0);
    check({tag, ".nbr_we"}, a_nbr_we, 0);
    check({tag, ".nbr_di"}, a_nbr_di, 0);
    check({tag, ".obj_we_di"}, {a_obj_we, a_obj_di[27:0]}, 0);
    check({tag, ".busy_done"}, {a_busy, a_done}, 0);
    check({tag, ".ovf_err"}, {a_ovf, a_err}, 0);
  endtask

  task automatic check_case1(input string tag);
    exp_q = '{2, 2, 3}; check_tbl({tag, ".v1"}, 0);
    exp_q = '{2, 1, 3}; check_tbl({tag, ".v2"}, 11);
    exp_q = '{2, 1, 2}; check_tbl({tag, ".v3"}, 22);
    check({tag, ".ovf"}, r_ovf, 0);
    check({tag, ".err"}, r_err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nz, hit;
    rst = 1'b0;
    start_req = 1'b0;
    run_sel = 1'b0;
    tb_wipe = 1'b0;
    tb_wipe_val = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_a_zero("reset");
    check("reset.b_busy_ovf_err", {b_busy, b_ovf, b_err, b_nbr_we}, 0);
    rst = 1'b0;

    // single triangle
    wipe('0);
    faces = '{1, 2, 3};
    load_obj(3);
    run("t1", 1'b0);
    check_case1("t1");

    // two faces sharing edge 1-3
    wipe('0);
    faces = '{1, 2, 3, 1, 3, 4};
    load_obj(4);
    run("t2", 1'b0);
    exp_q = '{3, 2, 3, 4}; check_tbl("t2.v1", 0);
    exp_q = '{2, 1, 3};    check_tbl("t2.v2", 11);
    exp_q = '{3, 1, 2, 4}; check_tbl("t2.v3", 22);
    exp_q = '{2, 1, 3};    check_tbl("t2.v4", 33);
    check("t2.ovf", r_ovf, 0);

    // MAX_NBR=2: vertex 1 fills up
    wipe('0);
    faces = '{1, 2, 3, 1, 4, 5};
    load_obj(5);
    run("t3", 1'b1);
    exp_q = '{2, 2, 3}; check_tbl("t3.v1", 0);
    exp_q = '{2, 1, 3}; check_tbl("t3.v2", 3);
    exp_q = '{2, 1, 5}; check_tbl("t3.v4", 9);
    exp_q = '{2, 1, 4}; check_tbl("t3.v5", 12);
    check("t3.ovf", r_ovf, 1);
    check("t3.err", r_err, 0);

    // sticky overflow clears on the next start
    wipe('0);
    faces = '{1, 2, 3};
    load_obj(3);
    run("t3b", 1'b1);
    exp_q = '{2, 1, 2}; check_tbl("t3b.v3", 6);
    check("t3b.ovf", r_ovf, 0);

    // out-of-range index skips the face
`ifdef NBR_CLEAR_EN
    wipe(32'hDEAD_BEEF);
`else
    wipe('0);
`endif
    faces = '{1, 2, 7};
    load_obj(3);
    run("t4", 1'b0);
    check("t4.err", r_err, 1);
    check("t4.ovf", r_ovf, 0);
    nz = 0;
    for (int i = 0; i < 33; i++) if (nbr_rd(i) != 0) nz++;
    check("t4.table_zero_words", nz, 0);

    // degenerate pair
    wipe('0);
    faces = '{2, 2, 3};
    load_obj(3);
    run("t5", 1'b0);
    exp_q = '{0};    check_tbl("t5.v1", 0);
    exp_q = '{1, 3}; check_tbl("t5.v2", 11);
    exp_q = '{1, 2}; check_tbl("t5.v3", 22);
    check("t5.err", r_err, 0);

    // table-fit boundary: 47*11=517 > 512, 46*11=506 fits
    wipe('0);
    faces.delete();
    load_obj(47);
    run("t6a", 1'b0);
    check("t6a.err", r_err, 1);
    nz = 0;
    for (int i = 0; i < 512; i++) if (nbr_rd(i) != 0) nz++;
    check("t6a.no_writes", nz, 0);
    load_obj(46);
    run("t6b", 1'b0);
    check("t6b.err", r_err, 0);

    // async reset while scanning, then rerun the first case
    wipe('0);
    faces = '{1, 2, 3, 1, 3, 4};
    load_obj(4);
    run_sel = 1'b0;
    @(negedge clk);
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    hit = 0;
    for (int c = 0; c < 2000 && hit == 0; c++) begin
      @(negedge clk);
      if (a_state == 4'd7) hit = 1;
    end
    check("rst.reached_scan", hit, 1);
    #2 rst = 1'b1;
    #1 check_a_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
`ifdef NBR_CLEAR_EN
    wipe(32'h0000_0007);
`else
    wipe('0);
`endif
    faces = '{1, 2, 3};
    load_obj(3);
    run("t7", 1'b0);
    check_case1("t7");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/neighbor_table_builder.md
# neighbor_table_builder

Parametrised successor to the mesh neighbor-list builder: walks the face list of a triangle mesh stored in the object RAM and builds a per-vertex adjacency table in the neighbor RAM. Adds a strided, non-overlapping table layout, an optional table-clear pass, degenerate-pair skipping, vertex-index range checking, sticky overflow and error flags, and a done pulse. Sits between the OBJ loader and the subdivision datapath; it owns both RAM ports while `busy`.

## Interface
Parameters:
- `ADDR_W`, 9: RAM address width (both RAMs).
- `DATA_W`, 32: RAM word width; multiple of 8.
- `MAX_NBR`, 10: neighbor slots per vertex; table stride `STRIDE = MAX_NBR+1`.
- `CNT_W`, `$clog2(MAX_NBR+1)`: internal neighbor-count width.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin build; sampled only in IDLE.
- `RAM_OBJ_Do`, `RAM_NBR_Do`  in  DATA_W  RAM read data, valid the cycle after the address is presented.
- `RAM_OBJ_EN`, `RAM_NBR_EN`  out  1  RAM enables.
- `RAM_OBJ_A`, `RAM_NBR_A`  out  ADDR_W  RAM addresses.
- `RAM_OBJ_WE`, `RAM_NBR_WE`  out  DATA_W/8  byte write enables; OBJ is always 0.
- `RAM_OBJ_Di`, `RAM_NBR_Di`  out  DATA_W  write data; OBJ is always 0.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE.
- `done`  out  1  one-cycle pulse at completion.
- `overflow`  out  1  sticky; a neighbor was dropped because the list was full.
- `err`  out  1  sticky; a vertex index was out of range, or the table does not fit.

## Operation
- OBJ layout: word 0 = V. Words 1..3V = coordinates, which are ignored. Word 3V+1 = F. The next 3F words are 1-based vertex indices a,b,c per face.
- NBR layout: vertex v uses base `(v-1)*STRIDE`. Word base holds the count (zero-extended). Words base+1..base+count hold neighbor indices.
- States: IDLE → RD_V → RD_F → [CLEAR] → RD_FACE → PAIR → LOOKUP → SCAN → APPEND → PAIR … → DONE → IDLE.
- RD_V / RD_F: latch V and F. If `V*STRIDE > 2^ADDR_W`, set `err` and go to DONE.
- RD_FACE: issue 3 consecutive reads. If F faces have been consumed, go to DONE.
  - Any index equal to 0 or greater than V sets `err`; that face is skipped.
- PAIR: step through the ordered pairs (a,b),(a,c),(b,a),(b,c),(c,a),(c,b). A pair with curr==test is skipped. After the sixth pair, return to RD_FACE.
- LOOKUP: read the count at the base of curr.
- SCAN: read slots 1..count in order. On a match, return to PAIR with no write. When count is exhausted, go to APPEND.
- APPEND:
  - If count==MAX_NBR, set `overflow` and write nothing.
  - Otherwise write `test` to slot count+1 in one cycle, then count+1 to base in the next cycle (WE all-ones).
- All address arithmetic is modulo 2^ADDR_W. OBJ addresses beyond range wrap; software guarantees `3V+3F+2 ≤ 2^ADDR_W`.
- `start` while busy is ignored. `overflow`/`err` clear on accepting a new `start`.

## Timing
- Reset values: all outputs 0, including EN, WE, A, Di, `busy`, `done`, `overflow`, `err`. State = IDLE.
- All outputs are registered. Reads have 1-cycle latency: the address is driven in cycle n and `Do` is captured in cycle n+1.
- Start: `start`=1 in IDLE at edge n → `busy`=1 and `RAM_OBJ_A`=0 after edge n.
- Lookup costs 2 cycles plus 1 per scanned slot. Append costs 2 write cycles. A skipped pair costs 1 cycle.
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then IDLE. The cycle after `done`, `start` is accepted again.
- Reset asserted mid-operation: outputs return to reset values immediately (async), including WE=0. Partial table contents are undefined.

## Configuration
- `NBR_CLEAR_EN` defined: the CLEAR state writes 0 to NBR words 0..V*STRIDE-1, one word per cycle, before RD_FACE.
- Undefined: CLEAR is absent and the table must be pre-zeroed by software. Stale counts are used as-is.

## Test plan
- V=3, F=1, face (1,2,3), MAX_NBR=10 → NBR[0..2]=2,2,3; NBR[11..13]=2,1,3; NBR[22..24]=2,1,2; `done` pulses once; `overflow`=`err`=0.
- V=4, faces (1,2,3),(1,3,4) → v1 list {2,3,4}, v3 {1,2,4}, v4 {1,3}, v2 {1,3}; shared edge not duplicated.
- MAX_NBR=2, faces (1,2,3),(1,4,5), V=5 → v1 count 2 = {2,3}; `overflow`=1; v4 {1,5}.
- V=3, face (1,2,7) → `err`=1; with `NBR_CLEAR_EN` all 33 table words 0; `done` pulses.
- Face (2,2,3) → v2 {3}, v3 {2}; no self-neighbor.
- `rst` pulsed mid-SCAN → all outputs 0 the same cycle. Then rerun the first case: identical result (clear enabled).
